// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - unified memory port arbiter between fetch (IF) and data (MEM) requesters
//
// Serialises IF fetches and MEM loads/stores onto one registered memory port.
// Data requests win over fetches. A fetch killed by a taken branch still runs
// to completion on the bus but is not acknowledged. Every access is bounded by
// an optional watchdog.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   if_req/if_addr/flush_if   fetch request, PC, taken-branch flush
//   if_ack/if_rdata           fetch completion pulse and instruction word
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_wmask         data request, store flag, address, data, byte enables
//   dm_ack/dm_rdata           data completion pulse and load data
//   stall_if/stall_mem        stall requests to the pipeline control
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_wmask       registered memory request fields
//   mem_ready/mem_rdata       memory completion and read data (same cycle)
//   bus_err                   one-cycle pulse when an access times out
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                flush_if,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wmask,
  output logic                dm_ack,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);
  localparam bit WD_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {ST_IDLE, ST_IF_BUSY, ST_DM_BUSY} state_t;

  state_t              state_q, state_d;
  logic                drop_q, drop_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wmask_q, mem_wmask_d;

  logic done_w, timeout_w, finish_w;
  logic grant_dm, grant_if;

  // mem_req_q is high exactly while an access is outstanding, so it also
  // masks mem_ready pulses that arrive while the port is idle.
  assign done_w    = mem_req_q & mem_ready;
  assign timeout_w = WD_EN & mem_req_q & ~mem_ready & (wait_cnt_q == CNT_LAST);
  assign finish_w  = done_w | timeout_w;

  assign dm_ack   = (state_q == ST_DM_BUSY) & finish_w;
  assign if_ack   = (state_q == ST_IF_BUSY) & finish_w & ~drop_q & ~flush_if;
  assign dm_rdata = timeout_w ? '0 : mem_rdata;
  assign if_rdata = timeout_w ? '0 : mem_rdata;
  assign bus_err  = timeout_w;

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = dm_req & ~dm_ack;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    wait_cnt_d  = wait_cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    grant_dm    = 1'b0;
    grant_if    = 1'b0;

    if (mem_req_q && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (dm_req) begin
          grant_dm = 1'b1;
        end else if (if_req && !flush_if) begin
          grant_if = 1'b1;
        end
      end
      ST_IF_BUSY: begin
        if (flush_if) begin
          drop_d = 1'b1;
        end
        if (timeout_w) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
        end else if (done_w) begin
          // Chaining excludes the fetch that just completed.
          drop_d = 1'b0;
          if (dm_req) begin
            grant_dm = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
          end
        end
      end
      ST_DM_BUSY: begin
        if (timeout_w) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end else if (done_w) begin
          // dm_req is still high in its own ack cycle, so it is excluded here.
          if (if_req && !flush_if) begin
            grant_if = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    if (grant_dm) begin
      state_d     = ST_DM_BUSY;
      mem_req_d   = 1'b1;
      mem_we_d    = dm_we;
      mem_addr_d  = dm_addr;
      mem_wdata_d = dm_wdata;
      mem_wmask_d = dm_wmask;
      wait_cnt_d  = '0;
      drop_d      = 1'b0;
    end
    if (grant_if) begin
      state_d     = ST_IF_BUSY;
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr;
      mem_wdata_d = '0;
      mem_wmask_d = '0;
      wait_cnt_d  = '0;
      drop_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drop_q      <= 1'b0;
      wait_cnt_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req, flush_if, dm_req, dm_we, mem_ready;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_wmask;
  logic        if_ack, dm_ack, stall_if, stall_mem, mem_req, mem_we, bus_err;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;

  logic        if_req1, flush_if1, dm_req1, dm_we1, mem_ready1;
  logic [31:0] if_addr1, dm_addr1, dm_wdata1, mem_rdata1;
  logic [3:0]  dm_wmask1;
  logic        if_ack1, dm_ack1, stall_if1, stall_mem1, mem_req1, mem_we1, bus_err1;
  logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;
  logic [3:0]  mem_wmask1;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u_dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .flush_if(flush_if),
    .if_ack(if_ack), .if_rdata(if_rdata), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wmask(dm_wmask), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .stall_if(stall_if), .stall_mem(stall_mem), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) u_dut_nowd (
    .clk(clk), .rst(rst), .if_req(if_req1), .if_addr(if_addr1), .flush_if(flush_if1),
    .if_ack(if_ack1), .if_rdata(if_rdata1), .dm_req(dm_req1), .dm_we(dm_we1),
    .dm_addr(dm_addr1), .dm_wdata(dm_wdata1), .dm_wmask(dm_wmask1), .dm_ack(dm_ack1),
    .dm_rdata(dm_rdata1), .stall_if(stall_if1), .stall_mem(stall_mem1), .mem_req(mem_req1),
    .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_wmask(mem_wmask1),
    .mem_ready(mem_ready1), .mem_rdata(mem_rdata1), .bus_err(bus_err1)
  );

  typedef struct packed {
    logic        st;
    logic [31:0] d;
  } dm_exp_t;

  int          checks = 0;
  int          failures = 0;
  bit          rnd_on = 1'b0;
  bit          if_done, dm_done;
  logic [31:0] if_exp[$];
  dm_exp_t     dm_exp[$];
  logic [31:0] tbmem[256];
  logic [31:0] refmem[256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] insn(input logic [31:0] a);
    return 32'h5A00_0013 ^ {a[15:0], a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; flush_if = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_wmask = 0;
    mem_ready = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    tick();
    rst = 0;
  endtask

  // Scoreboard monitor for the randomized phase.
  always @(negedge clk) begin
    if (rnd_on) begin
      if (if_ack) begin
        if (if_exp.size() == 0) begin
          checks++; failures++;
          $display("FAIL if_ack_unowned: got if_ack=1 expected no ack (no fetch outstanding)");
        end else begin
          chk("rnd if_rdata", if_rdata, if_exp.pop_front());
        end
      end
      if (dm_ack) begin
        if (dm_exp.size() == 0) begin
          checks++; failures++;
          $display("FAIL dm_ack_unowned: got dm_ack=1 expected no ack (no data access outstanding)");
        end else begin
          dm_exp_t e;
          e = dm_exp.pop_front();
          if (!e.st) chk("rnd dm_rdata", dm_rdata, e.d);
        end
      end
      chk("rnd bus_err", 32'(bus_err), 32'd0);
      if (mem_req && mem_addr < 32'h100) chk("rnd fetch we/wmask", 32'({mem_we, mem_wmask}), 32'd0);
    end
  end

  task automatic responder();
    int lat;
    logic [7:0] ix;
    lat = -1;
    while (!(if_done && dm_done)) begin
      tick();
      if (mem_req) begin
        if (lat < 0) lat = $urandom_range(0, 2);
        if (lat == 0) begin
          ix = mem_addr[9:2];
          mem_ready = 1;
          mem_rdata = tbmem[ix];
          if (mem_we) tbmem[ix] = merge(tbmem[ix], mem_wdata, mem_wmask);
          lat = -1;
        end else begin
          mem_ready = 0;
          mem_rdata = $urandom;
          lat--;
        end
      end else begin
        lat = -1;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
    mem_ready = 0;
  endtask

  task automatic if_proc(input int n);
    logic [31:0] a;
    int w;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      a = 32'($urandom_range(0, 63)) << 2;
      if_addr = a; if_req = 1; flush_if = 0;
      if_exp.push_back(insn(a));
      w = 0;
      forever begin
        @(negedge clk);
        if (if_ack) break;
        w++;
        if (w > 200) begin
          checks++; failures++;
          $display("FAIL if_wait: fetch %h got no if_ack expected ack within 200 cycles", a);
          break;
        end
        tick();
        if ($urandom_range(0, 15) == 0) begin
          // Taken branch: new PC, old fetch must never be acknowledged.
          a = 32'($urandom_range(0, 63)) << 2;
          if_addr = a; flush_if = 1;
          if (if_exp.size() > 0) if_exp[if_exp.size()-1] = insn(a);
        end else begin
          flush_if = 0;
        end
      end
      tick();
      if_req = 0; flush_if = 0;
    end
    if_done = 1;
  endtask

  task automatic dm_proc(input int n);
    logic [31:0] a, wd;
    logic [3:0]  m;
    logic        st;
    int          w;
    dm_exp_t     e;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      st = 1'($urandom_range(0, 1));
      a  = 32'h100 + (32'($urandom_range(0, 7)) << 2);
      wd = $urandom;
      m  = 4'($urandom_range(0, 15));
      dm_we = st; dm_addr = a; dm_wdata = wd; dm_wmask = m; dm_req = 1;
      e.st = st;
      if (st) begin
        refmem[a[9:2]] = merge(refmem[a[9:2]], wd, m);
        e.d = 32'd0;
      end else begin
        e.d = refmem[a[9:2]];
      end
      dm_exp.push_back(e);
      w = 0;
      forever begin
        @(negedge clk);
        if (dm_ack) break;
        w++;
        if (w > 200) begin
          checks++; failures++;
          $display("FAIL dm_wait: access %h got no dm_ack expected ack within 200 cycles", a);
          break;
        end
        tick();
      end
      tick();
      dm_req = 0;
    end
    dm_done = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int nerr, nack;
    if_req1 = 0; if_addr1 = 0; flush_if1 = 0; dm_req1 = 0; dm_we1 = 0;
    dm_addr1 = 32'h200; dm_wdata1 = 0; dm_wmask1 = 0; mem_ready1 = 0; mem_rdata1 = 32'hFFFF_FFFF;

    // Reset state
    rst = 1; idle_inputs(); mem_ready = 1;
    tick(); tick();
    @(negedge clk);
    chk("rst mem_req", 32'(mem_req), 0);
    chk("rst mem_we", 32'(mem_we), 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wmask", 32'(mem_wmask), 0);
    chk("rst acks", 32'({if_ack, dm_ack, bus_err}), 0);

    // Simultaneous requests: data first, fetch chained without gap
    do_reset();
    if_req = 1; if_addr = 32'h40; dm_req = 1; dm_we = 0; dm_addr = 32'h100; dm_wmask = 4'hF;
    @(negedge clk);
    chk("sim c0 mem_req", 32'(mem_req), 0);
    tick(); mem_ready = 1; mem_rdata = 32'hAAAA_0001;
    @(negedge clk);
    chk("sim c1 mem_req", 32'(mem_req), 1);
    chk("sim c1 mem_addr", mem_addr, 32'h100);
    chk("sim c1 dm_ack", 32'(dm_ack), 1);
    chk("sim c1 dm_rdata", dm_rdata, 32'hAAAA_0001);
    chk("sim c1 if_ack", 32'(if_ack), 0);
    tick(); dm_req = 0; mem_rdata = 32'hBBBB_0002;
    @(negedge clk);
    chk("sim c2 mem_req", 32'(mem_req), 1);
    chk("sim c2 mem_addr", mem_addr, 32'h40);
    chk("sim c2 fetch we/wmask", 32'({mem_we, mem_wmask}), 0);
    chk("sim c2 if_ack", 32'(if_ack), 1);
    chk("sim c2 if_rdata", if_rdata, 32'hBBBB_0002);
    tick(); if_req = 0; mem_ready = 0;
    @(negedge clk);
    chk("sim c3 mem_req", 32'(mem_req), 0);

    // Variable latency fetch
    do_reset();
    if_req = 1; if_addr = 32'h40;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("lat c%0d stall_if", c), 32'({stall_if, if_ack}), 32'b10);
      tick();
    end
    mem_ready = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("lat c4 if_ack", 32'(if_ack), 1);
    chk("lat c4 if_rdata", if_rdata, 32'h1234_5678);
    chk("lat c4 stall_if", 32'(stall_if), 0);
    chk("lat c4 bus_err", 32'(bus_err), 0);
    tick(); if_req = 0; mem_ready = 0;

    // Flush during an IF_BUSY access
    do_reset();
    if_req = 1; if_addr = 32'h40;
    tick();
    @(negedge clk);
    chk("flb c1 mem_req", 32'(mem_req), 1);
    tick(); flush_if = 1; if_addr = 32'h80;
    @(negedge clk);
    chk("flb c2 if_ack", 32'(if_ack), 0);
    tick(); flush_if = 0; mem_ready = 1; mem_rdata = 32'hDEAD_0003;
    @(negedge clk);
    chk("flb c3 dropped if_ack", 32'(if_ack), 0);
    tick(); mem_ready = 0;
    @(negedge clk);
    chk("flb c4 mem_req", 32'(mem_req), 0);
    tick(); mem_ready = 1; mem_rdata = 32'h0000_0C80;
    @(negedge clk);
    chk("flb c5 mem_addr", mem_addr, 32'h80);
    chk("flb c5 if_ack", 32'(if_ack), 1);
    chk("flb c5 if_rdata", if_rdata, 32'h0000_0C80);
    tick(); if_req = 0; mem_ready = 0;

    // Flush while idle blocks the grant for that cycle only
    do_reset();
    if_req = 1; if_addr = 32'hC0; flush_if = 1;
    tick(); flush_if = 0;
    @(negedge clk);
    chk("fli c1 mem_req", 32'(mem_req), 0);
    tick(); mem_ready = 1; mem_rdata = 32'h0000_00C0;
    @(negedge clk);
    chk("fli c2 mem_req", 32'(mem_req), 1);
    chk("fli c2 mem_addr", mem_addr, 32'hC0);
    chk("fli c2 if_ack", 32'(if_ack), 1);
    tick(); if_req = 0; mem_ready = 0;

    // Watchdog timeout with TIMEOUT=4
    do_reset();
    dm_req = 1; dm_we = 0; dm_addr = 32'h104; mem_rdata = 32'hFFFF_FFFF;
    for (int c = 1; c < 4; c++) begin
      tick();
      @(negedge clk);
      chk($sformatf("to c%0d bus_err/dm_ack", c), 32'({bus_err, dm_ack}), 0);
    end
    tick();
    @(negedge clk);
    chk("to c4 bus_err", 32'(bus_err), 1);
    chk("to c4 dm_ack", 32'(dm_ack), 1);
    chk("to c4 dm_rdata", dm_rdata, 0);
    tick(); dm_req = 0;
    @(negedge clk);
    chk("to c5 mem_req", 32'(mem_req), 0);
    chk("to c5 bus_err", 32'(bus_err), 0);

    // Reset while a store is outstanding
    do_reset();
    dm_req = 1; dm_we = 1; dm_addr = 32'h108; dm_wdata = 32'h5555_AAAA; dm_wmask = 4'hF;
    tick(); rst = 1;
    @(negedge clk);
    chk("rma c1 mem_req/we", 32'({mem_req, mem_we}), 32'b11);
    tick(); rst = 0; mem_ready = 1;
    @(negedge clk);
    chk("rma c2 mem_req", 32'(mem_req), 0);
    chk("rma c2 dm_ack", 32'(dm_ack), 0);
    tick(); mem_ready = 0;
    @(negedge clk);
    chk("rma c3 regrant mem_req", 32'(mem_req), 1);
    chk("rma c3 mem_addr", mem_addr, 32'h108);
    tick(); mem_ready = 1;
    @(negedge clk);
    chk("rma c4 dm_ack", 32'(dm_ack), 1);
    tick(); dm_req = 0; mem_ready = 0;

    // Watchdog disabled (TIMEOUT=0): access waits indefinitely
    dm_req1 = 1;
    nerr = 0; nack = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (bus_err1) nerr++;
      if (dm_ack1) nack++;
      tick();
    end
    @(negedge clk);
    chk("nowd bus_err count", 32'(nerr), 0);
    chk("nowd dm_ack count", 32'(nack), 0);
    chk("nowd mem_req", 32'(mem_req1), 1);
    chk("nowd stall_mem", 32'(stall_mem1), 1);

    // Randomized traffic against the scoreboard
    do_reset();
    for (int i = 0; i < 256; i++) begin
      tbmem[i] = (i < 64) ? insn(32'(i) << 2) : $urandom;
      refmem[i] = tbmem[i];
    end
    if_done = 0; dm_done = 0;
    rnd_on = 1;
    fork
      if_proc(40);
      dm_proc(40);
      responder();
    join
    tick();
    rnd_on = 0;
    chk("rnd if queue drained", 32'(if_exp.size()), 0);
    chk("rnd dm queue drained", 32'(dm_exp.size()), 0);
    for (int i = 64; i < 72; i++) chk($sformatf("rnd mem word %0d", i), tbmem[i], refmem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
